cmp_arbiter: RTL and testbench
==============================

CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (1..64).
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter ID_W, default 2, requester-index width; 2**ID_W >= N_REQ.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester request valid, bit i = requester i.
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester accept, at most one bit high.
REQ-008 SHALL have port req_a  input  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_b  input  N_REQ*WIDTH  operand B, same packing as req_a.
REQ-010 SHALL have port rsp_valid  output  1  result register holds a valid result.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port rsp_id  output  ID_W  index of requester that owns the result.
REQ-013 SHALL have ports rsp_equal, rsp_greater, rsp_less  output  1 each  unsigned A==B, A>B, A<B.
REQ-014 SHALL have port busy  output  1  equals rsp_valid.

Function
REQ-015 SHALL share one unsigned WIDTH-bit comparator among all requesters, one comparison per cycle max.
REQ-016 SHALL be a two-state machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 SHALL compute accept = EMPTY or (FULL and rsp_ready).
REQ-018 SHALL, when accept, assert req_ready for exactly the granted requester: first i with req_valid[i] searching round-robin from (last_grant+1) mod N_REQ; otherwise req_ready = 0.
REQ-019 SHALL treat req_valid[i] && req_ready[i] as transfer; result registered on that edge, latency 1 cycle.
REQ-020 SHALL update last_grant only on a transfer.
REQ-021 SHALL, on transfer, load rsp_id = i and exactly one of equal/greater/less = 1.
REQ-022 SHALL transition EMPTY->FULL on transfer; FULL->EMPTY on rsp_ready with no transfer; FULL->FULL on rsp_ready with transfer (new result replaces old, zero bubble).
REQ-023 SHALL hold rsp_id and flags stable while rsp_valid && !rsp_ready.
REQ-024 SHALL hold last flags and rsp_id after drain (rsp_valid=0); consumers ignore them.
REQ-025 SHALL, with a single active requester and rsp_ready=1, sustain one result per cycle.
REQ-026 SHALL ignore req_valid bits at index >= N_REQ (none exist) and never grant a requester whose req_valid is 0.
REQ-027 SHALL make req_ready depend only on state, rsp_ready, req_valid, last_grant (no operand path).

Reset
REQ-028 SHALL, while rst_n=0, force rsp_valid=0, rsp_id=0, all flags=0, busy=0, state EMPTY, last_grant=N_REQ-1 (requester 0 first priority).
REQ-029 SHALL discard any held result when reset asserts mid-operation; no result re-emitted after release.
REQ-030 SHALL keep req_ready=0 while rst_n=0.

Configuration
REQ-031 SHALL, with macro CMP_ARB_STATS_EN defined, add output gnt_cnt  N_REQ*16  per-requester 16-bit transfer counters, packed like req_a, saturating at 0xFFFF, reset to 0.
REQ-032 SHALL, without CMP_ARB_STATS_EN, omit gnt_cnt port and counter logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: reset release, req_valid=4'b0001, a0=5, b0=5, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, equal=1, greater=0, less=0.
REQ-034 SHALL cover: req_valid=4'b1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-035 SHALL cover: rsp_valid=1, rsp_ready=0 for 3 cycles with req_valid=4'b0100 -> req_ready=0, rsp_id/flags unchanged; rsp_ready=1 -> req_ready[2]=1 same cycle, new result next cycle.
REQ-036 SHALL cover: WIDTH=8, a=8'hFF, b=8'h00 -> greater=1; a=8'h00, b=8'hFF -> less=1 (unsigned).
REQ-037 SHALL cover: rst_n pulsed low while FULL -> rsp_valid=0 immediately (async), after release requester 0 granted first when req_valid=4'b1111.
REQ-038 SHALL cover (CMP_ARB_STATS_EN): 70000 transfers from requester 1 -> gnt_cnt[31:16]=16'hFFFF, other counters 0.

Source files
------------

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter in front of one shared unsigned comparator.
// Each accepted request is compared in one cycle. The result sits in a
// single-entry register until the consumer takes it.
// A new result may replace the drained one on the same edge, so there is no bubble.
// Optional build macro CMP_ARB_STATS_EN adds gnt_cnt: a saturating
// 16-bit transfer counter for each requester.
module cmp_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_equal,
    output logic                   rsp_greater,
    output logic                   rsp_less,
    output logic                   busy
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]    gnt_cnt
`endif
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       state;
    logic [ID_W-1:0]  last_grant;
    logic [N_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_found;
    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    // Round-robin search: the first valid requester above last_grant wins.
    // If none is found, the search wraps to requester 0 and goes up to last_grant.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that skips an assignment would infer a latch.
        gnt_oh    = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && req_valid[i] && (i > int'(last_grant))) begin
                gnt_found = 1'b1;
                gnt_oh[i] = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && req_valid[i] && (i <= int'(last_grant))) begin
                gnt_found = 1'b1;
                gnt_oh[i] = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
    end

    // Handshake: accept when the result slot is empty or is being drained this cycle.
    // req_ready depends only on control signals, so no operand bit reaches it.
    always_comb begin
        accept    = (state == S_EMPTY) || rsp_ready;
        req_ready = (accept && rst_n) ? gnt_oh : '0;
        xfer      = |req_ready;
    end

    // Operand mux: pass the granted requester's operands to the shared comparator.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_oh[i]) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // EMPTY/FULL state and the result register, loaded on every transfer.
    // last_grant moves only when a transfer happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the result fields are reset as well, so no stale result is visible after reset.
            state       <= S_EMPTY;
            last_grant  <= ID_W'(N_REQ - 1);
            rsp_id      <= '0;
            rsp_equal   <= 1'b0;
            rsp_greater <= 1'b0;
            rsp_less    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment, so every flop samples values from before the edge.
            if (xfer) begin
                state       <= S_FULL;
                last_grant  <= gnt_id;
                rsp_id      <= gnt_id;
                rsp_equal   <= (a_sel == b_sel);
                rsp_greater <= (a_sel >  b_sel);
                rsp_less    <= (a_sel <  b_sel);
            end else if (rsp_ready) begin
                state <= S_EMPTY;
            end
        end
    end

    // busy and rsp_valid both show that the result register is occupied.
    always_comb begin
        rsp_valid = (state == S_FULL);
        busy      = (state == S_FULL);
    end

`ifdef CMP_ARB_STATS_EN
    logic [15:0] cnt_q [N_REQ];

    // Transfer counter for each requester. It stops at 0xFFFF and does not wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Pack the counters with the same layout as req_a.
    always_comb begin
        gnt_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Testbench for cmp_arbiter. A reference model predicts the grant each cycle,
// and its expected results go into a scoreboard queue.
// Entries are popped and compared when the DUT registers a result.
module tb_cmp_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_equal;
    logic                   rsp_greater;
    logic                   rsp_less;
    logic                   busy;
`ifdef CMP_ARB_STATS_EN
    logic [N_REQ*16-1:0]    gnt_cnt;
`endif

    logic [WIDTH-1:0] a_op [N_REQ];
    logic [WIDTH-1:0] b_op [N_REQ];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_op[i];
            req_b[i*WIDTH +: WIDTH] = b_op[i];
        end
    end

    cmp_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_equal   (rsp_equal),
        .rsp_greater (rsp_greater),
        .rsp_less    (rsp_less),
        .busy        (busy)
`ifdef CMP_ARB_STATS_EN
        ,
        .gnt_cnt     (gnt_cnt)
`endif
    );

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            eq;
        logic            gt;
        logic            lt;
    } rsp_t;

    rsp_t sb [$];
    rsp_t m_res;
    logic m_full;
    int   m_last;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] cur_rsp();
        rsp_t r;
        r.id = rsp_id;
        r.eq = rsp_equal;
        r.gt = rsp_greater;
        r.lt = rsp_less;
        return 64'(r);
    endfunction

    // Runs one clock cycle. The task checks req_ready against the model before the edge.
    // If the model predicts a transfer, it pushes the expected result to the scoreboard.
    // After the edge it checks rsp_valid, busy and the result fields.
    task automatic cycle();
        int                g;
        logic              acc;
        logic              xf;
        logic [N_REQ-1:0]  exp_rdy;
        rsp_t              r;
        #1;
        acc = !m_full || rsp_ready;
        g = -1;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (m_last + k) % N_REQ;
            if (g < 0 && ((req_valid >> idx) & 4'd1) != 4'd0) g = idx;
        end
        xf = acc && (g >= 0);
        exp_rdy = xf ? (N_REQ'(1) << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (xf) begin
            r.id = ID_W'(g);
            r.eq = (a_op[g] == b_op[g]);
            r.gt = (a_op[g] >  b_op[g]);
            r.lt = (a_op[g] <  b_op[g]);
            sb.push_back(r);
            m_last = g;
            m_full = 1'b1;
        end else if (rsp_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(m_full));
        check("busy", 64'(busy), 64'(m_full));
        if (xf) m_res = sb.pop_front();
        check("rsp_fields", cur_rsp(), 64'(m_res));
    endtask

    // Asserts reset (the design resets asynchronously) and checks the outputs while reset is low.
    // It then releases reset at a negedge with no requests pending.
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fields", cur_rsp(), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        m_full = 1'b0;
        m_last = N_REQ - 1;
        m_res  = '0;
        sb.delete();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rsp_t held;
        for (int i = 0; i < N_REQ; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        m_full = 1'b0;
        m_last = N_REQ - 1;
        m_res  = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // First request after reset: operands equal.
        req_valid = 4'b0001; a_op[0] = 8'd5; b_op[0] = 8'd5; rsp_ready = 1'b1;
        cycle();
        check("first_eq", cur_rsp(), 64'({2'd0, 1'b1, 1'b0, 1'b0}));
        req_valid = '0;
        cycle();

        // All four requesters active: grants should come out in order 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                a_op[i] = WIDTH'($urandom);
                b_op[i] = WIDTH'($urandom);
            end
            cycle();
            check("rr_order", 64'(rsp_id), 64'(k % N_REQ));
        end

        // Consumer stalls for 3 cycles: the result must hold and no grant is given.
        rsp_ready = 1'b0; req_valid = 4'b0100;
        a_op[2] = 8'h10; b_op[2] = 8'h20;
        held = rsp_t'(cur_rsp());
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_hold", cur_rsp(), 64'(held));
        end
        rsp_ready = 1'b1;
        cycle();
        check("stall_new_id", 64'(rsp_id), 64'd2);
        check("stall_new_lt", 64'(rsp_less), 64'd1);

        // Extreme operand values, compared as unsigned.
        req_valid = 4'b0001;
        a_op[0] = 8'hFF; b_op[0] = 8'h00;
        cycle();
        check("unsigned_gt", 64'({rsp_equal, rsp_greater, rsp_less}), 64'(3'b010));
        a_op[0] = 8'h00; b_op[0] = 8'hFF;
        cycle();
        check("unsigned_lt", 64'({rsp_equal, rsp_greater, rsp_less}), 64'(3'b001));

        // Random traffic with random consumer backpressure.
        for (int k = 0; k < 300; k++) begin
            req_valid = N_REQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                a_op[i] = WIDTH'($urandom);
                b_op[i] = ($urandom_range(0, 3) == 0) ? a_op[i] : WIDTH'($urandom);
            end
            cycle();
        end

        // Reset asserted while a result is held; requester 0 must win first afterwards.
        req_valid = 4'b0010; rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        req_valid = '0;
        cycle();
        check("pre_reset_full", 64'(rsp_valid), 64'd1);
        do_reset();
        req_valid = 4'b1111; rsp_ready = 1'b1;
        cycle();
        check("post_reset_id", 64'(rsp_id), 64'd0);
        req_valid = '0;
        cycle();
        cycle();
        check("sb_empty", 64'(sb.size()), 64'd0);

`ifdef CMP_ARB_STATS_EN
        // Counter saturation: only requester 1 transfers.
        do_reset();
        req_valid = 4'b0010; rsp_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            check("gnt_cnt", 64'(gnt_cnt[i*16 +: 16]), (i == 1) ? 64'hFFFF : 64'd0);
        end
        req_valid = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
